// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: holds the L/R halves and commits one Feistel round per slot
// using an external f datapath, for encrypt (ascending key index) or decrypt (descending).
module des_round_sequencer #(
   parameter int unsigned NUM_ROUNDS = 16,
   parameter int unsigned F_LATENCY  = 0,
   parameter int unsigned IDX_W      = 4
) (
   input  logic             wClk,
   input  logic             wReset,
   input  logic             wInValid,
   output logic             wInReady,
   input  logic [63:0]      wInData,
   input  logic             wDecrypt,
   output logic [31:0]      wFRight,
   output logic [IDX_W-1:0] wRoundIdx,
   input  logic [31:0]      wFOut,
   output logic             wOutValid,
   input  logic             wOutReady,
   output logic [63:0]      wOutData,
   output logic             wBusy
);

   localparam int unsigned WaitW = (F_LATENCY > 0) ? $clog2(F_LATENCY + 1) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(F_LATENCY);
   localparam logic [IDX_W-1:0] RndLast  = IDX_W'(NUM_ROUNDS - 1);

   typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

   state_e             state_q, state_d;
   logic [31:0]        l_q, l_d;
   logic [31:0]        r_q, r_d;
   logic [IDX_W-1:0]   rnd_q, rnd_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic               mode_q, mode_d;

   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      r_d     = r_q;
      rnd_d   = rnd_q;
      wait_d  = wait_q;
      mode_d  = mode_q;
      case (state_q)
         StIdle: begin
            if (wInValid) begin
               l_d     = wInData[63:32];
               r_d     = wInData[31:0];
               mode_d  = wDecrypt;
               rnd_d   = '0;
               wait_d  = '0;
               state_d = StRound;
            end
         end
         StRound: begin
            // f is only sampled on the last cycle of a slot; earlier values are don't-care
            if (wait_q == WaitLast) begin
               l_d    = r_q;
               r_d    = l_q ^ wFOut;
               wait_d = '0;
               rnd_d  = rnd_q + IDX_W'(1);
               if (rnd_q == RndLast) begin
                  state_d = StDone;
               end
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StDone: begin
            if (wOutReady) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wClk) begin
      if (wReset) begin
         state_q <= StIdle;
         l_q     <= '0;
         r_q     <= '0;
         rnd_q   <= '0;
         wait_q  <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         r_q     <= r_d;
         rnd_q   <= rnd_d;
         wait_q  <= wait_d;
         mode_q  <= mode_d;
      end
   end

   assign wInReady  = (state_q == StIdle);
   assign wBusy     = (state_q != StIdle);
   assign wOutValid = (state_q == StDone);
   assign wOutData  = wOutValid ? {r_q, l_q} : 64'h0;
   assign wFRight   = r_q;
   assign wRoundIdx = mode_q ? (RndLast - rnd_q) : rnd_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: two instances (F_LATENCY 0 and 2) with stub f functions,
// results compared against a plain Feistel-loop model.
module tb_des_round_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int fsel   = 0;  // 0: f=0, 1: f=ktab[idx]
   logic [31:0] ktab [16];

   // instance 0: F_LATENCY = 0
   logic        in_valid0 = 0, in_ready0, decrypt0 = 0, out_valid0, out_ready0 = 0, busy0;
   logic [63:0] in_data0 = '0, out_data0;
   logic [31:0] f_right0, f_out0;
   logic [3:0]  round_idx0;
   assign f_out0 = (fsel == 1) ? ktab[round_idx0] : 32'h0;

   des_round_sequencer #(.NUM_ROUNDS(16), .F_LATENCY(0), .IDX_W(4)) dut0 (
      .wClk(clk), .wReset(rst), .wInValid(in_valid0), .wInReady(in_ready0), .wInData(in_data0),
      .wDecrypt(decrypt0), .wFRight(f_right0), .wRoundIdx(round_idx0), .wFOut(f_out0),
      .wOutValid(out_valid0), .wOutReady(out_ready0), .wOutData(out_data0), .wBusy(busy0)
   );

   // instance 1: F_LATENCY = 2, f = ~R
   logic        in_valid1 = 0, in_ready1, out_valid1, out_ready1 = 0, busy1;
   logic [63:0] in_data1 = '0, out_data1;
   logic [31:0] f_right1, f_out1;
   logic [3:0]  round_idx1;
   assign f_out1 = ~f_right1;

   des_round_sequencer #(.NUM_ROUNDS(16), .F_LATENCY(2), .IDX_W(4)) dut1 (
      .wClk(clk), .wReset(rst), .wInValid(in_valid1), .wInReady(in_ready1), .wInData(in_data1),
      .wDecrypt(1'b0), .wFRight(f_right1), .wRoundIdx(round_idx1), .wFOut(f_out1),
      .wOutValid(out_valid1), .wOutReady(out_ready1), .wOutData(out_data1), .wBusy(busy1)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Feistel network evaluated directly: 16 rounds, halves swapped at the end
   function automatic logic [63:0] model(input logic [63:0] blk, input bit dec, input int sel);
      logic [31:0] l, r, f, t;
      l = blk[63:32];
      r = blk[31:0];
      for (int i = 0; i < 16; i++) begin
         case (sel)
            1:       f = ktab[dec ? 15 - i : i];
            2:       f = ~r;
            default: f = 32'h0;
         endcase
         t = r;
         r = l ^ f;
         l = t;
      end
      return {r, l};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start0(input logic [63:0] blk, input bit dec);
      for (int t = 0; t < 50 && !in_ready0; t++) tick();
      check("start_ready", in_ready0, 1);
      in_data0  = blk;
      decrypt0  = dec;
      in_valid0 = 1;
      tick();
      in_valid0 = 0;
      decrypt0  = ~dec;  // must be ignored mid-block
      in_data0  = {$urandom, $urandom};
   endtask

   task automatic rounds0(input bit dec);
      for (int n = 0; n < 16; n++) begin
         check($sformatf("round_idx[%0d]", n), round_idx0, dec ? 15 - n : n);
         check($sformatf("no_valid[%0d]", n), out_valid0, 0);
         if (n == 3) begin
            check("busy_round", busy0, 1);
            check("ready_round", in_ready0, 0);
         end
         tick();
      end
      check("valid_at_16", out_valid0, 1);
   endtask

   task automatic drain0();
      out_ready0 = 1;
      tick();
      out_ready0 = 0;
      check("drain_ready", in_ready0, 1);
      check("drain_valid", out_valid0, 0);
      check("drain_busy", busy0, 0);
   endtask

   initial begin
      logic [63:0] blk, enc, hold;
      logic [63:0] expq [$];
      int          acc [$];
      int          n_out, cyc;
      bit          dec, do_acc, do_out;

      for (int i = 0; i < 16; i++) ktab[i] = $urandom;
      tick();
      tick();
      rst = 0;
      check("rst_ready", in_ready0, 1);
      check("rst_valid", out_valid0, 0);
      check("rst_busy", busy0, 0);
      check("rst_data", out_data0, 0);
      check("rst_fright", f_right0, 0);
      check("rst_idx", round_idx0, 0);

      // f = 0: halves just swap
      fsel = 0;
      start0(64'h0123456789ABCDEF, 0);
      rounds0(0);
      check("zero_f_data", out_data0, 64'h89ABCDEF01234567);
      drain0();

      // key table: encrypt then decrypt recovers the block
      fsel = 1;
      for (int k = 0; k < 2; k++) begin
         blk = {$urandom, $urandom};
         start0(blk, 0);
         rounds0(0);
         enc = out_data0;
         check("enc_data", enc, model(blk, 0, 1));
         drain0();
         start0(enc, 1);
         rounds0(1);
         check("dec_model", out_data0, model(enc, 1, 1));
         check("dec_roundtrip", out_data0, blk);
         drain0();
      end

      // backpressure in DONE; a stray input pulse is ignored
      blk = {$urandom, $urandom};
      start0(blk, 0);
      rounds0(0);
      hold = out_data0;
      check("bp_data", hold, model(blk, 0, 1));
      for (int i = 0; i < 10; i++) begin
         in_valid0 = (i == 4);
         if (i == 4) in_data0 = {$urandom, $urandom};
         check("bp_valid", out_valid0, 1);
         check("bp_stable", out_data0, hold);
         check("bp_ready", in_ready0, 0);
         tick();
      end
      in_valid0 = 0;
      drain0();
      tick();
      check("bp_no_capture", busy0, 0);

      // reset in round 7
      start0({$urandom, $urandom}, 0);
      for (int i = 0; i < 7; i++) tick();
      check("pre_rst_idx", round_idx0, 7);
      rst = 1;
      tick();
      rst = 0;
      check("mid_rst_ready", in_ready0, 1);
      check("mid_rst_valid", out_valid0, 0);
      check("mid_rst_fright", f_right0, 0);
      check("mid_rst_idx", round_idx0, 0);
      check("mid_rst_data", out_data0, 0);
      blk = {$urandom, $urandom};
      start0(blk, 1);
      rounds0(1);
      check("post_rst_data", out_data0, model(blk, 1, 1));
      drain0();

      // F_LATENCY = 2 instance
      blk       = {$urandom, $urandom};
      in_data1  = blk;
      in_valid1 = 1;
      tick();
      in_valid1 = 0;
      for (int n = 0; n < 48; n++) begin
         check($sformatf("lat2_idx[%0d]", n), round_idx1, n / 3);
         if (n == 47) check("lat2_no_valid_47", out_valid1, 0);
         tick();
      end
      check("lat2_valid_48", out_valid1, 1);
      check("lat2_data", out_data1, model(blk, 0, 2));
      out_ready1 = 1;
      tick();
      out_ready1 = 0;
      check("lat2_drain", in_ready1, 1);

      // back-to-back stream with continuous valid/ready
      out_ready0 = 1;
      dec        = 1'($urandom);
      in_data0   = {$urandom, $urandom};
      decrypt0   = dec;
      in_valid0  = 1;
      n_out      = 0;
      cyc        = 0;
      while (n_out < 3 && cyc < 200) begin
         do_acc = in_valid0 && in_ready0;
         do_out = out_valid0 && out_ready0;
         hold   = out_data0;
         if (do_acc) expq.push_back(model(in_data0, decrypt0, 1));
         tick();
         cyc++;
         if (do_out) begin
            n_out++;
            check("b2b_queue_nonempty", expq.size() > 0, 1);
            if (expq.size() > 0) check("b2b_data", hold, expq.pop_front());
         end
         if (do_acc) begin
            acc.push_back(cyc);
            if (acc.size() >= 3) in_valid0 = 0;
            in_data0 = {$urandom, $urandom};
            decrypt0 = 1'($urandom);
         end
      end
      in_valid0  = 0;
      out_ready0 = 0;
      check("b2b_outputs", n_out, 3);
      check("b2b_accepts", acc.size(), 3);
      if (acc.size() == 3) begin
         check("b2b_gap1", acc[1] - acc[0], 18);
         check("b2b_gap2", acc[2] - acc[1], 18);
      end
      check("b2b_leftover", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
